// File: rtl/parity_frame_rx_if.sv
// Serial-in / frame-out bundle for parity_frame_rx; master drives the bit stream, slave is the receiver.
// Outputs are all registered in the receiver; x_valid is the only flow control (no backpressure).
interface parity_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              x;
   logic              x_valid;
   logic [DATA_W-1:0] data_out;
   logic              frame_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   modport master (
      output x, x_valid,
      input  data_out, frame_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  x, x_valid,
      output data_out, frame_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/parity_frame_rx.sv
// Deframes start/DATA_W data (LSB first)/parity/stop serial frames and flags parity and framing errors.
// Result pulses one cycle after the stop-bit sample; x_valid=0 stalls all state, no backpressure upstream.
module parity_frame_rx #(
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic               clk,
   input  logic               reset,
   parity_frame_rx_if.slave   bus
);
   localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam bit ODD_BIT = (PARITY_ODD != 0);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              run_par;
   logic              par_err;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] data_q;
   logic              fvld_q;
   logic              perr_q;
   logic              ferr_q;
   logic              busy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         run_par <= 1'b0;
         par_err <= 1'b0;
         shreg   <= '0;
         data_q  <= '0;
         fvld_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fvld_q <= 1'b0;
         if (bus.x_valid) begin
            case (state)
               IDLE: begin
                  if (!bus.x) begin
                     state   <= DATA;
                     cnt     <= '0;
                     run_par <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
               DATA: begin
                  // Shift in at the MSB so the first bit ends up in bit 0.
                  shreg   <= {bus.x, shreg[DATA_W-1:1]};
                  run_par <= run_par ^ bus.x;
                  cnt     <= cnt + 1'b1;
                  if (cnt == CNT_W'(DATA_W - 1))
                     state <= PARITY;
               end
               PARITY: begin
                  run_par <= run_par ^ bus.x;
                  par_err <= ((run_par ^ bus.x) != ODD_BIT);
                  state   <= STOP;
               end
               STOP: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  data_q <= shreg;
                  perr_q <= par_err;
                  ferr_q <= ~bus.x;
                  fvld_q <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.data_out    = data_q;
   assign bus.frame_valid = fvld_q;
   assign bus.parity_err  = perr_q;
   assign bus.frame_err   = ferr_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboarded bench: one bit stream drives an even-parity and an odd-parity receiver side by side.
module tb_parity_frame_rx;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   parity_frame_rx_if #(.DATA_W(8)) bus_e ();
   parity_frame_rx_if #(.DATA_W(8)) bus_o ();
   assign bus_o.x       = bus_e.x;
   assign bus_o.x_valid = bus_e.x_valid;

   parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_e (.clk(clk), .reset(reset), .bus(bus_e));
   parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_o (.clk(clk), .reset(reset), .bus(bus_o));

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } exp_t;

   exp_t q_e[$];
   exp_t q_o[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus_e.busy) busy_cnt <= busy_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cmp_frame(input string tag, input exp_t e, input logic [7:0] d,
                            input logic pe, input logic fe);
      check({tag, "_data"},   32'(d),   32'(e.data));
      check({tag, "_perr"},   32'(pe),  32'(e.perr));
      check({tag, "_ferr"},   32'(fe),  32'(e.ferr));
      check({tag, "_cycle"},  32'(cyc), 32'(e.cyc));
   endtask

   // Monitor: every frame_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus_e.frame_valid) begin
         check("even_pulse_expected", 32'(q_e.size() != 0), 32'd1);
         if (q_e.size() != 0)
            cmp_frame("even", q_e.pop_front(), bus_e.data_out, bus_e.parity_err, bus_e.frame_err);
      end
      if (bus_o.frame_valid) begin
         check("odd_pulse_expected", 32'(q_o.size() != 0), 32'd1);
         if (q_o.size() != 0)
            cmp_frame("odd", q_o.pop_front(), bus_o.data_out, bus_o.parity_err, bus_o.frame_err);
      end
   end

   task automatic put_bit(input logic b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         bus_e.x_valid = 1'b0;
         bus_e.x       = 1'($urandom);
      end
      @(negedge clk);
      bus_e.x       = b;
      bus_e.x_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus_e.x_valid = 1'b0;
         bus_e.x       = 1'b1;
      end
      @(posedge clk);
   endtask

   function automatic int gap_of(input int gmax);
      return (gmax > 0) ? int'($urandom_range(gmax, 1)) : 0;
   endfunction

   // Expected results are hand-computed per frame; pushed when the stop bit is sampled.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gmax,
                             input logic pe_even, input logic pe_odd);
      exp_t e;
      put_bit(1'b0, gap_of(gmax));
      for (int i = 0; i < 8; i++) put_bit(d[i], gap_of(gmax));
      put_bit(p, gap_of(gmax));
      put_bit(s, gap_of(gmax));
      #1;
      e.data = d; e.ferr = ~s; e.cyc = cyc;
      e.perr = pe_even; q_e.push_back(e);
      e.perr = pe_odd;  q_o.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_e_data"},  32'(bus_e.data_out),    32'd0);
      check({tag, "_e_fvld"},  32'(bus_e.frame_valid), 32'd0);
      check({tag, "_e_perr"},  32'(bus_e.parity_err),  32'd0);
      check({tag, "_e_ferr"},  32'(bus_e.frame_err),   32'd0);
      check({tag, "_e_busy"},  32'(bus_e.busy),        32'd0);
      check({tag, "_o_data"},  32'(bus_o.data_out),    32'd0);
      check({tag, "_o_fvld"},  32'(bus_o.frame_valid), 32'd0);
      check({tag, "_o_perr"},  32'(bus_o.parity_err),  32'd0);
      check({tag, "_o_ferr"},  32'(bus_o.frame_err),   32'd0);
      check({tag, "_o_busy"},  32'(bus_o.busy),        32'd0);
   endtask

   initial begin
      int b0;
      bus_e.x       = 1'b1;
      bus_e.x_valid = 1'b0;
      reset         = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      // 0xA5 even parity bit 0; busy spans the DATA, PARITY and STOP states (8+1+1 cycles).
      put_bit(1'b1, 0);
      put_bit(1'b1, 0);
      b0 = busy_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      check("busy_cycles", 32'(busy_cnt - b0), 32'd10);
      idle(2);

      // Wrong-for-even parity on 0xA5, then 0x01 with parity 1.
      send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
      idle(1);
      send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      idle(1);

      // Framing error: stop bit 0.
      send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      idle(2);
      check("idle_after_ferr", 32'(bus_e.busy), 32'd0);

      // Stall gaps of 1-3 cycles between every bit.
      send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0, 1'b1);
      idle(2);

      // Reset mid-frame after 4 data bits; the partial frame must vanish.
      put_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) put_bit(i[0], 0);
      @(negedge clk);
      reset = 1'b0; bus_e.x_valid = 1'b1; bus_e.x = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      reset = 1'b1; bus_e.x_valid = 1'b0; bus_e.x = 1'b1;
      idle(3);
      send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      idle(1);

      // Back-to-back: second start bit right after the first stop bit.
      send_frame(8'h12, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      send_frame(8'h34, 1'b1, 1'b1, 0, 1'b0, 1'b1);
      idle(1);

      for (int i = 0; i < 20 && (q_e.size() != 0 || q_o.size() != 0); i++) @(negedge clk);
      check("drain_even", 32'(q_e.size()), 32'd0);
      check("drain_odd",  32'(q_o.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
